// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
// Bundles the fetch-queue control, instruction-memory and decode-side signals.
//   halt, redirect, redirect_pc : fetch control from the pipeline
//   mem_req, mem_addr           : instruction-memory request (held until ack)
//   mem_ack, mem_rdata          : instruction-memory response
//   out_valid, out_pc,
//   out_instr, out_ready        : head-of-queue handshake toward IF/ID
//   count                       : current queue occupancy
// Modport slave is the queue side, modport master is the pipeline/memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
);
    logic                     halt;
    logic                     redirect;
    logic [PC_W-1:0]          redirect_pc;
    logic                     mem_req;
    logic [PC_W-1:0]          mem_addr;
    logic                     mem_ack;
    logic [INS_W-1:0]         mem_rdata;
    logic                     out_valid;
    logic [PC_W-1:0]          out_pc;
    logic [INS_W-1:0]         out_instr;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  halt, redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_instr, count
    );

    modport master (
        output halt, redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Instruction prefetch queue: issues at most one instruction-memory request at
// a time, stores returned {pc, instr} pairs in a DEPTH-entry FIFO and presents
// the head entry to decode. A redirect flushes the queue and retargets fetch;
// a request already in flight at redirect time is completed and its data
// dropped (DISCARD state).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : instr_fetch_queue_if.slave (control, memory and decode signals)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_queue_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // r_busy marks a request that was presented and not yet acknowledged;
    // while set, the request and its address are frozen in r_req_addr.
    logic                r_busy;
    logic                w_busy_next;
    logic [PC_W-1:0]     r_req_addr;
    logic [PC_W-1:0]     r_fetch_pc;
    logic [PC_W-1:0]     w_fetch_pc_next;

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    w_wr_ptr_next;
    logic [PTR_W-1:0]    w_rd_ptr_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;

    logic [PC_W-1:0]     r_pc_mem  [DEPTH];
    logic [INS_W-1:0]    r_ins_mem [DEPTH];

    logic                w_mem_req;
    logic [PC_W-1:0]     w_mem_addr;
    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    logic [PC_W-1:0]     w_redirect_target;

    always_comb begin
        w_out_valid       = (r_count != '0);
        w_redirect_target = bus.redirect_pc & ~PC_W'(3);

        // A fresh request is only offered in FETCH with room guaranteed for
        // its data; an outstanding one stays up regardless of halt/redirect.
        w_mem_req = 1'b0;
        if (!reset) begin
            w_mem_req = r_busy |
                        ((r_state == ST_FETCH) && !bus.halt &&
                         (r_count < CNT_W'(DEPTH)));
        end
        w_mem_addr = r_busy ? r_req_addr : r_fetch_pc;

        w_ack  = w_mem_req & bus.mem_ack;
        w_push = w_ack & (r_state == ST_FETCH) & ~bus.redirect;
        w_pop  = w_out_valid & bus.out_ready & ~bus.redirect;

        w_busy_next = w_mem_req & ~bus.mem_ack;

        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (bus.redirect && w_mem_req && !bus.mem_ack) begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // Request is always up here, so any ack completes it.
                if (bus.mem_ack) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_FETCH;
        endcase

        w_fetch_pc_next = r_fetch_pc;
        if (bus.redirect) begin
            w_fetch_pc_next = w_redirect_target;
        end else if (w_push) begin
            w_fetch_pc_next = w_mem_addr + PC_W'(4);
        end

        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (bus.redirect) begin
            // Flush: no push happens this cycle, so aligning the read pointer
            // to the write pointer empties the ring.
            w_rd_ptr_next = r_wr_ptr;
            w_count_next  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_busy     <= 1'b0;
            r_req_addr <= '0;
            r_fetch_pc <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_req_addr <= w_mem_addr;
            r_fetch_pc <= w_fetch_pc_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= w_mem_addr;
            r_ins_mem[r_wr_ptr] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.out_valid = w_out_valid;
    // Head fields read as zero when empty so reset presents clean outputs.
    assign bus.out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]  : '0;
    assign bus.out_instr = w_out_valid ? r_ins_mem[r_rd_ptr] : '0;
    assign bus.count     = r_count;

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter PC_W, default 9, program-counter width in bits.
REQ-002 Parameter INS_W, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 halt  input  1  suppress new memory requests while high.
REQ-007 redirect  input  1  branch/jump flush from the execute stage.
REQ-008 redirect_pc  input  PC_W  new fetch target on redirect.
REQ-009 mem_req  output  1  instruction-memory request.
REQ-010 mem_addr  output  PC_W  request byte address.
REQ-011 mem_ack  input  1  request complete; mem_rdata valid this cycle.
REQ-012 mem_rdata  input  INS_W  fetched instruction.
REQ-013 out_valid  output  1  head entry valid toward the IF/ID register.
REQ-014 out_pc  output  PC_W  PC of head entry.
REQ-015 out_instr  output  INS_W  instruction of head entry.
REQ-016 out_ready  input  1  decode consumes head entry (low = stall).
REQ-017 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 States SHALL be FETCH (may issue), DISCARD (outstanding request squashed); one outstanding request max.
REQ-019 In FETCH, mem_req SHALL be 1 iff halt=0 and count<DEPTH; mem_addr SHALL equal fetch_pc.
REQ-020 Once mem_req=1, mem_req and mem_addr SHALL stay stable until the cycle mem_ack=1, regardless of halt or redirect.
REQ-021 mem_ack with mem_req=1 in FETCH and redirect=0 SHALL push {mem_addr, mem_rdata} and set fetch_pc=mem_addr+4.
REQ-022 mem_ack when mem_req=0 SHALL be ignored.
REQ-023 fetch_pc arithmetic SHALL be modulo 2^PC_W (e.g. 508+4 -> 0 for PC_W=9).
REQ-024 Pushed entry SHALL appear at out_valid/out_pc/out_instr the next cycle (1-cycle latency, no bypass).
REQ-025 Pop SHALL occur when out_valid=1 and out_ready=1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; FIFO order SHALL be preserved across pointer wrap.
REQ-027 Issue gating on count<DEPTH SHALL guarantee no overflow; pop when empty SHALL be impossible (out_valid=0).
REQ-028 redirect=1 SHALL empty the queue (count=0, out_valid=0 next cycle), ignore any same-cycle pop or push, and set fetch_pc=redirect_pc with bits [1:0] forced to 0.
REQ-029 redirect while mem_req=1 and mem_ack=0 SHALL enter DISCARD; redirect with same-cycle mem_ack SHALL stay in FETCH and drop the data.
REQ-030 In DISCARD, mem_req SHALL stay high on the old address; on mem_ack data SHALL be dropped and state SHALL return to FETCH.
REQ-031 A second redirect in DISCARD SHALL overwrite fetch_pc and remain in DISCARD.
REQ-032 halt=1 SHALL not abort an outstanding request; its data SHALL be pushed normally; draining SHALL continue; deasserting halt SHALL resume at fetch_pc.

Reset
REQ-033 reset=1 SHALL asynchronously set state=FETCH, fetch_pc=0, queue empty, count=0, out_valid=0, out_pc=0, out_instr=0.
REQ-034 While reset=1, mem_req SHALL be 0 and mem_addr 0; first request (addr 0) may assert the cycle after reset deasserts if halt=0.
REQ-035 Reset mid-request SHALL abandon the outstanding request; a late mem_ack after reset with mem_req=0 SHALL be ignored.

Verification
REQ-036 Zero-wait ack every cycle, out_ready=1 -> out_pc sequence 0,4,8,... one per cycle, count<=1.
REQ-037 out_ready=0, ack every cycle -> 4 entries 0..12 queued, count=4, mem_req=0; out_ready=1 -> pops in order, fetch resumes at 16.
REQ-038 Request at addr 20 outstanding, redirect_pc=0x1A3 -> DISCARD, mem_req held on 20; ack drops data; next request addr 0x1A0, no stale entry output.
REQ-039 fetch_pc=508, acks continue -> next addresses 0, 4 (wrap), out_pc order 508, 0, 4.
REQ-040 halt=1 with request on addr 8 pending, ack 3 cycles later -> entry 8 pushed, no new mem_req; halt=0 -> request addr 12.
REQ-041 Assert reset while count=3 and request pending -> immediately out_valid=0, count=0, mem_req=0; after release first request addr 0.
